// File: rtl/dbnc_pkg.sv
// Shared constants and helpers for the debounce sampler.
// The defaults target a 100 MHz board clock.
package dbnc_pkg;

    // 100 MHz / 50001 gives a sample strobe of about 2 kHz
    localparam int DEF_DIV_END  = 50000;
    localparam int DEF_STABLE_N = 4;

    function automatic int clog2(input int unsigned value);
        int unsigned v;
        int          r;
        r = 0;
        v = (value > 0) ? value - 1 : 0;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced input: synchroniser, stability counter, registered level
// and one-cycle edge pulses.
module debounce_channel
    import dbnc_pkg::*;
#(
    parameter int SYNC_N   = 2,
    parameter int STABLE_N = DEF_STABLE_N
) (
    input  logic CLK,
    input  logic RST,
    input  logic i_tick,
    input  logic i_btn,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    localparam int SCNT_W = clog2(STABLE_N) + 1;

    logic [SYNC_N-1:0] r_sync;
    logic [SCNT_W-1:0] r_scnt;
    logic              r_level;
    logic              r_rise;
    logic              r_fall;
    logic              w_s;

    assign w_s = r_sync[SYNC_N-1];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_N-2:0], i_btn};
        end
    end

    // The counter clears on the accepting sample, so it never exceeds STABLE_N-1
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_scnt  <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (i_tick) begin
                if (w_s != r_level) begin
                    if (r_scnt == SCNT_W'(STABLE_N - 1)) begin
                        r_level <= w_s;
                        r_scnt  <= '0;
                        r_rise  <= w_s;
                        r_fall  <= ~w_s;
                    end else begin
                        r_scnt <= r_scnt + SCNT_W'(1);
                    end
                end else begin
                    r_scnt <= '0;
                end
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/debounce_sampler.sv
// Multi-channel debouncer with a shared sample-tick divider.
// All outputs are registered and synchronous to CLK.
module debounce_sampler
    import dbnc_pkg::*;
#(
    parameter int NCH      = 5,
    parameter int DIV_END  = DEF_DIV_END,
    parameter int DIV_W    = 16,
    parameter int STABLE_N = DEF_STABLE_N,
    parameter int SYNC_N   = 2
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           EN,
    input  logic [NCH-1:0] BTN_IN,
    output logic [NCH-1:0] BTN_OUT,
    output logic [NCH-1:0] RISE,
    output logic [NCH-1:0] FALL,
    output logic           TICK
);

    logic [DIV_W-1:0] r_cnt;
    logic             r_tick;

    // EN low holds the count, so a resumed divider keeps its phase
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (EN) begin
            if (r_cnt == DIV_W'(DIV_END)) begin
                r_cnt  <= '0;
                r_tick <= 1'b1;
            end else begin
                r_cnt  <= r_cnt + DIV_W'(1);
                r_tick <= 1'b0;
            end
        end else begin
            r_tick <= 1'b0;
        end
    end

    assign TICK = r_tick;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        debounce_channel #(
            .SYNC_N   (SYNC_N),
            .STABLE_N (STABLE_N)
        ) u_ch (
            .CLK     (CLK),
            .RST     (RST),
            .i_tick  (r_tick),
            .i_btn   (BTN_IN[g]),
            .o_level (BTN_OUT[g]),
            .o_rise  (RISE[g]),
            .o_fall  (FALL[g])
        );
    end

endmodule

// File: tb/tb_debounce_sampler.sv
// Scoreboard bench for debounce_sampler: DIV_END=3, STABLE_N=4, SYNC_N=2, NCH=5.
// Edge-pulse events are queued by the stimulus and checked by a negedge monitor.
module tb_debounce_sampler;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       EN  = 1'b1;
    logic [4:0] BTN_IN = '0;
    logic [4:0] BTN_OUT;
    logic [4:0] RISE;
    logic [4:0] FALL;
    logic       TICK;

    debounce_sampler #(
        .NCH      (5),
        .DIV_END  (3),
        .DIV_W    (16),
        .STABLE_N (4),
        .SYNC_N   (2)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .EN      (EN),
        .BTN_IN  (BTN_IN),
        .BTN_OUT (BTN_OUT),
        .RISE    (RISE),
        .FALL    (FALL),
        .TICK    (TICK)
    );

    always #5 CLK = ~CLK;

    // Edge count since the latest reset release
    int cyc;
    always @(posedge CLK or posedge RST) begin
        if (RST) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    int checks   = 0;
    int failures = 0;
    int phase    = 0;

    typedef struct {
        int         c;
        logic [4:0] out;
        logic [4:0] rise;
        logic [4:0] fall;
    } ev_t;

    ev_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cyc=%0d)", name, act, req, cyc);
        end
    endtask

    task automatic to_edge(input int n);
        while (cyc < n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic expect_ev(input int c, input logic [4:0] o, input logic [4:0] r,
                             input logic [4:0] f);
        ev_t e;
        e.c = c; e.out = o; e.rise = r; e.fall = f;
        sb.push_back(e);
    endtask

    always @(negedge CLK) begin
        logic exp_tick;
        ev_t  e;
        exp_tick = (cyc >= 4) && (cyc % 4 == 0) &&
                   !(phase == 0 && cyc >= 151 && cyc <= 171);
        chk("tick", {31'b0, TICK}, {31'b0, exp_tick});
        if ((RISE | FALL) != 5'b0) begin
            if (sb.size() == 0) begin
                chk("unexpected_pulse", {22'b0, RISE, FALL}, 32'h0);
            end else begin
                e = sb.pop_front();
                chk("pulse_cycle", cyc, e.c);
                chk("pulse_btn_out", {27'b0, BTN_OUT}, {27'b0, e.out});
                chk("pulse_rise", {27'b0, RISE}, {27'b0, e.rise});
                chk("pulse_fall", {27'b0, FALL}, {27'b0, e.fall});
            end
        end
    end

    initial begin
        repeat (3) @(negedge CLK);
        RST = 1'b0;

        // 1: idle after reset
        for (int i = 1; i <= 16; i++) begin
            to_edge(i);
            chk("t1_idle", {17'b0, BTN_OUT, RISE, FALL}, 32'h0);
        end

        // 2: channel 0 rises
        BTN_IN[0] = 1'b1;
        expect_ev(33, 5'b00001, 5'b00001, 5'b00000);
        to_edge(32);
        chk("t2_not_yet", {27'b0, BTN_OUT}, 32'h0);
        to_edge(34);
        chk("t2_level", {27'b0, BTN_OUT}, 32'h01);
        chk("t2_rise_gone", {27'b0, RISE}, 32'h0);

        // 3: channel 1 bounces, then settles high
        for (int k = 0; k < 12; k++) begin
            to_edge(40 + 5 * k);
            BTN_IN[1] = (k % 2 == 0);
        end
        to_edge(100);
        BTN_IN[1] = 1'b1;
        expect_ev(117, 5'b00011, 5'b00010, 5'b00000);
        to_edge(116);
        chk("t3_quiet", {27'b0, BTN_OUT}, 32'h01);

        // 4: channel 0 falls
        to_edge(120);
        BTN_IN[0] = 1'b0;
        expect_ev(137, 5'b00010, 5'b00000, 5'b00001);

        // 5: enable dropped mid-qualification
        to_edge(140);
        BTN_IN[2] = 1'b1;
        expect_ev(177, 5'b00110, 5'b00100, 5'b00000);
        to_edge(150);
        EN = 1'b0;
        for (int i = 151; i <= 170; i++) begin
            to_edge(i);
            chk("t5_hold", {27'b0, BTN_OUT}, 32'h02);
        end
        EN = 1'b1;
        to_edge(176);
        chk("t5_before", {27'b0, BTN_OUT}, 32'h02);

        // 6: reset during qualification
        to_edge(180);
        BTN_IN[0] = 1'b1;
        BTN_IN[4] = 1'b1;
        to_edge(194);
        phase = 1;
        RST   = 1'b1;
        #1;
        chk("t6_reset_zero", {16'b0, BTN_OUT, RISE, FALL, TICK}, 32'h0);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        expect_ev(17, 5'b10111, 5'b10111, 5'b00000);
        to_edge(16);
        chk("t6_not_yet", {27'b0, BTN_OUT}, 32'h0);
        to_edge(24);
        chk("sb_drained", sb.size(), 32'd0);
        chk("final_level", {27'b0, BTN_OUT}, 32'h17);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
